// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants for the transmit and receive sides.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // Serial bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_w, input int parity_en);
        return 1 + data_w + ((parity_en != 0) ? 1 : 0) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter; tick marks the last clock of each serial bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, valid/ready byte input, LSB-first serial out.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int             BIT_W       = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic           PAR_ODD_BIT = (PARITY_ODD != 0);

    uart_state_t       state_q,  state_d;
    logic [DATA_W-1:0] shift_q,  shift_d;
    logic [BIT_W-1:0]  bit_q,    bit_d;
    logic              par_q,    par_d;
    logic              tx_q,     tx_d;
    logic              ready_q,  ready_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              w_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .tick (w_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    // Parity is frozen with the data so later input changes cannot alter it.
                    par_d   = (^tx_data) ^ PAR_ODD_BIT;
                    tx_d    = UART_START_LVL;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (w_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = UART_IDLE_LVL;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    tx_d    = UART_IDLE_LVL;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    tx_d    = UART_IDLE_LVL;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = UART_IDLE_LVL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= UART_IDLE_LVL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx (no parity, even, odd parity).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int NDUT = 3;   // 0: no parity, 1: even parity, 2: odd parity

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [10:0] bits;      // bit i = i-th serial bit on the line
        int          nbits;
        int          done_off;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid  [NDUT];
    logic [DW-1:0] data   [NDUT];
    logic          tx_o   [NDUT];
    logic          rdy_o  [NDUT];
    logic          busy_o [NDUT];
    logic          done_o [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(N), .DATA_W(DW), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
        .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(rdy_o[0]), .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
    uart_tx #(.CLKS_PER_BIT(N), .DATA_W(DW), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
        .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(rdy_o[1]), .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
    uart_tx #(.CLKS_PER_BIT(N), .DATA_W(DW), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
        .clk(clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(rdy_o[2]), .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, d, $time, act, exp);
        end
    endtask

    function automatic int fbits(input int d);
        return frame_bits(DW, (d == 0) ? 0 : 1);
    endfunction

    // Line contents of a whole frame, built from the framing rules.
    function automatic logic [10:0] frame_of(input logic [7:0] b, input int d);
        logic [10:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        if (d != 0) begin
            ones = $countones(b);
            f[9] = (d == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        end
        return f;
    endfunction

    // ---------------- timing reference model ----------------
    int          cyc = 0;
    int          e0       [NDUT];
    bit          m_busy   [NDUT];
    bit          m_done   [NDUT];
    bit          m_tx     [NDUT];
    logic [10:0] m_bits   [NDUT];
    int          done_cnt [NDUT];
    bit          model_on = 1'b0;

    task automatic model_step();
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            if (rst === 1'b1) begin
                m_busy[d] = 1'b0; m_done[d] = 1'b0; m_tx[d] = 1'b1;
            end else if (m_busy[d] && (cyc == e0[d] + fbits(d) * N)) begin
                m_busy[d] = 1'b0; m_done[d] = 1'b1; m_tx[d] = 1'b1;
            end else begin
                m_done[d] = 1'b0;
                if (!m_busy[d]) begin
                    if (valid[d] === 1'b1) begin
                        e0[d]     = cyc;
                        m_busy[d] = 1'b1;
                        m_bits[d] = frame_of(data[d], d);
                        m_tx[d]   = 1'b0;
                    end else begin
                        m_tx[d] = 1'b1;
                    end
                end else begin
                    m_tx[d] = m_bits[d][(cyc - e0[d]) / N];
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (model_on) begin
            for (int d = 0; d < NDUT; d++) begin
                chk("model tx",    d, 32'(tx_o[d]),   32'(m_tx[d]));
                chk("model ready", d, 32'(rdy_o[d]),  32'(!m_busy[d]));
                chk("model busy",  d, 32'(busy_o[d]), 32'(m_busy[d]));
                chk("model done",  d, 32'(done_o[d]), 32'(m_done[d]));
                if (done_o[d] === 1'b1) done_cnt[d]++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input int d, input logic [7:0] b);
        chk("ready before send", d, 32'(rdy_o[d]), 32'd1);
        valid[d] = 1'b1;
        data[d]  = b;
        @(negedge clk);
        valid[d] = 1'b0;
        data[d]  = 8'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int pulses;
        int pulse_at;
        pulses   = 0;
        pulse_at = -1;
        start_frame(v.dut, v.data);
        for (int j = 0; j < v.nbits * N + 3; j++) begin
            if ((j % N) == N / 2 && (j / N) < v.nbits)
                chk("vec bit", v.dut, 32'(tx_o[v.dut]), 32'(v.bits[j / N]));
            if (done_o[v.dut] === 1'b1) begin
                pulses++;
                pulse_at = j;
            end
            if (j == v.done_off) chk("vec ready at done", v.dut, 32'(rdy_o[v.dut]), 32'd1);
            data[v.dut] = 8'($urandom);
            @(negedge clk);
        end
        chk("vec done pulses", v.dut, 32'(pulses), 32'd1);
        chk("vec done offset", v.dut, 32'(pulse_at), 32'(v.done_off));
    endtask

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int   dc;
        vec_t v;
        logic [10:0] f1;
        logic [10:0] f2;

        vecs[0] = '{0, 8'hA5, 11'b0_1_10100101_0, 10, 40};
        vecs[1] = '{1, 8'h07, 11'b1_1_00000111_0, 11, 44};
        vecs[2] = '{2, 8'h07, 11'b1_0_00000111_0, 11, 44};
        vecs[3] = '{0, 8'h00, 11'b0_1_00000000_0, 10, 40};
        vecs[4] = '{1, 8'hFF, 11'b1_0_11111111_0, 11, 44};
        vecs[5] = '{2, 8'h00, 11'b1_1_00000000_0, 11, 44};

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            valid[d] = 1'b0;
            data[d]  = '0;
        end
        repeat (3) @(negedge clk);
        model_on = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            chk("reset tx",    d, 32'(tx_o[d]),   32'd1);
            chk("reset ready", d, 32'(rdy_o[d]),  32'd1);
            chk("reset busy",  d, 32'(busy_o[d]), 32'd0);
            chk("reset done",  d, 32'(done_o[d]), 32'd0);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back with valid held high; data changes during the first frame.
        f1 = frame_of(8'h3C, 0);
        f2 = frame_of(8'hC3, 0);
        valid[0] = 1'b1;
        data[0]  = 8'h3C;
        @(negedge clk);
        data[0]  = 8'hC3;
        for (int j = 0; j < 90; j++) begin
            if (j < 40 && (j % N) == N / 2) chk("b2b frame1 bit", 0, 32'(tx_o[0]), 32'(f1[j / N]));
            if (j == 40) begin
                chk("b2b idle gap tx", 0, 32'(tx_o[0]), 32'd1);
                chk("b2b gap ready",   0, 32'(rdy_o[0]), 32'd1);
            end
            if (j == 41) begin
                chk("b2b second start", 0, 32'(tx_o[0]), 32'd0);
                valid[0] = 1'b0;
                data[0]  = 8'h00;
            end
            if (j > 41 && j < 81 && ((j - 41) % N) == N / 2)
                chk("b2b frame2 bit", 0, 32'(tx_o[0]), 32'(f2[(j - 41) / N]));
            @(negedge clk);
        end

        // Reset in the middle of a frame.
        dc = done_cnt[0];
        start_frame(0, 8'hFF);
        for (int j = 0; j < 60; j++) begin
            if (j == 16) rst = 1'b1;
            if (j == 17) begin
                rst = 1'b0;
                chk("abort tx",    0, 32'(tx_o[0]),   32'd1);
                chk("abort ready", 0, 32'(rdy_o[0]),  32'd1);
                chk("abort busy",  0, 32'(busy_o[0]), 32'd0);
            end
            @(negedge clk);
        end
        chk("abort no done", 0, 32'(done_cnt[0]), 32'(dc));
        v = '{0, 8'h55, 11'b0_1_01010101_0, 10, 40};
        run_vec(v);

        // Valid pulse while busy is ignored.
        dc = done_cnt[0];
        start_frame(0, 8'h5A);
        for (int j = 0; j < 90; j++) begin
            if (j == 9)  begin valid[0] = 1'b1; data[0] = 8'h99; end
            if (j == 10) begin valid[0] = 1'b0; data[0] = 8'h00; end
            @(negedge clk);
        end
        chk("busy valid single done", 0, 32'(done_cnt[0] - dc), 32'd1);

        // Randomized traffic on all three variants, checked by the model.
        for (int c = 0; c < 1500; c++) begin
            rst = (($urandom % 400) == 0);
            for (int d = 0; d < NDUT; d++) begin
                valid[d] = (($urandom % 4) == 0);
                data[d]  = 8'($urandom);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) valid[d] = 1'b0;
        repeat (60) @(negedge clk);
        for (int d = 0; d < NDUT; d++) chk("final idle ready", d, 32'(rdy_o[d]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
